// File: rtl/spram_bus_controller.sv
// spram_bus_controller: 32-bit valid/ready bus to 16-bit iCE40 SPRAM bridge with idle sleep
module spram_bus_controller #(
    parameter int IDLE_SLEEP_CYCLES = 64,
    parameter int WAKE_CYCLES       = 3
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        bus_valid_i,
    input  logic [12:0] bus_address_i,
    input  logic [3:0]  bus_wstrb_i,
    input  logic [31:0] bus_wdata_i,
    output logic        bus_ready_o,
    output logic [31:0] bus_rdata_o,
    output logic [13:0] spram_address_o,
    output logic [15:0] spram_datain_o,
    output logic [3:0]  spram_maskwren_o,
    output logic        spram_wren_o,
    output logic        spram_chipselect_o,
    output logic        spram_standby_o,
    output logic        spram_sleep_o,
    output logic        spram_poweroff_o,
    input  logic [15:0] spram_dataout_i
);
    localparam int CW = $clog2(IDLE_SLEEP_CYCLES + 2);
    localparam int WW = $clog2(WAKE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LO, HI, CAP, DONE, SLEEP, WAKE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [12:0]   addr_q, addr_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [13:0]   sp_addr_q, sp_addr_d;
    logic [15:0]   datain_q, datain_d;
    logic [3:0]    mask_q, mask_d;
    logic          wren_q, wren_d;
    logic          cs_q, cs_d;
    logic          sleep_q, sleep_d;
    logic          lo, hi, wr;

    // Next state, request latching, and the SPRAM-side outputs of the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus_valid_i) begin
                    addr_d  = bus_address_i;
                    wstrb_d = bus_wstrb_i;
                    wdata_d = bus_wdata_i;
                    state_d = LO;
                end else if (IDLE_SLEEP_CYCLES != 0 && cnt_q == CW'(IDLE_SLEEP_CYCLES - 1)) begin
                    state_d = SLEEP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LO:    state_d = HI;
            HI:    state_d = (wstrb_q == 4'b0000) ? CAP : DONE;
            CAP:   state_d = DONE;
            DONE:  state_d = IDLE;
            SLEEP: begin
                if (bus_valid_i) begin
                    addr_d  = bus_address_i;
                    wstrb_d = bus_wstrb_i;
                    wdata_d = bus_wdata_i;
                    wcnt_d  = WW'(WAKE_CYCLES - 1);
                    state_d = WAKE;
                end
            end
            WAKE: begin
                if (wcnt_q == '0) state_d = LO;
                else wcnt_d = wcnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        lo        = state_d == LO;
        hi        = state_d == HI;
        wr        = (lo || hi) && wstrb_d != 4'b0000;
        cs_d      = lo || hi;
        wren_d    = wr;
        sp_addr_d = cs_d ? {addr_d, hi} : 14'h0;
        datain_d  = wr ? (hi ? wdata_d[31:16] : wdata_d[15:0]) : 16'h0;
        mask_d    = wr ? (hi ? {wstrb_d[3], wstrb_d[3], wstrb_d[2], wstrb_d[2]}
                             : {wstrb_d[1], wstrb_d[1], wstrb_d[0], wstrb_d[0]}) : 4'h0;
        sleep_d   = state_d == SLEEP;
        ready_d   = state_d == DONE;
        rdata_d   = (state_q == HI && wstrb_q == 4'b0000) ? {rdata_q[31:16], spram_dataout_i} :
                    (state_q == CAP) ? {spram_dataout_i, rdata_q[15:0]} : rdata_q;
    end

    // State and registered outputs; reset leaves the SPRAM idle and awake
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            addr_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            sp_addr_q <= '0;
            datain_q  <= '0;
            mask_q    <= '0;
            wren_q    <= 1'b0;
            cs_q      <= 1'b0;
            sleep_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            sp_addr_q <= sp_addr_d;
            datain_q  <= datain_d;
            mask_q    <= mask_d;
            wren_q    <= wren_d;
            cs_q      <= cs_d;
            sleep_q   <= sleep_d;
        end
    end

    assign bus_ready_o        = ready_q;
    assign bus_rdata_o        = rdata_q;
    assign spram_address_o    = sp_addr_q;
    assign spram_datain_o     = datain_q;
    assign spram_maskwren_o   = mask_q;
    assign spram_wren_o       = wren_q;
    assign spram_chipselect_o = cs_q;
    assign spram_sleep_o      = sleep_q;
    assign spram_standby_o    = 1'b0;
    assign spram_poweroff_o   = 1'b1;
endmodule

// File: tb/tb_spram_bus_controller.sv
// tb_spram_bus_controller: directed checks of the SPRAM bus controller against a nibble-masked SPRAM model
module tb_spram_bus_controller;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid;
    logic [12:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic [13:0] sp_addr;
    logic [15:0] datain;
    logic [3:0]  mask;
    logic        wren, cs, standby, sleep, poweroff;
    logic [15:0] dout;
    logic [15:0] mem [0:16383];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spram_bus_controller #(.IDLE_SLEEP_CYCLES(8), .WAKE_CYCLES(3)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .bus_valid_i(valid), .bus_address_i(addr),
        .bus_wstrb_i(wstrb), .bus_wdata_i(wdata), .bus_ready_o(ready), .bus_rdata_o(rdata),
        .spram_address_o(sp_addr), .spram_datain_o(datain), .spram_maskwren_o(mask),
        .spram_wren_o(wren), .spram_chipselect_o(cs), .spram_standby_o(standby),
        .spram_sleep_o(sleep), .spram_poweroff_o(poweroff), .spram_dataout_i(dout)
    );

    always @(posedge clk) begin
        if (cs) begin
            if (wren) begin
                for (int n = 0; n < 4; n++)
                    if (mask[n]) mem[sp_addr][4*n +: 4] <= datain[4*n +: 4];
            end else begin
                dout <= mem[sp_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_txn(input logic [12:0] a, input logic [3:0] s, input logic [31:0] d,
                             input logic [13:0] lo_a, input logic [15:0] lo_d, input logic [3:0] lo_m,
                             input logic [15:0] hi_d, input logic [3:0] hi_m);
        valid = 1'b1; addr = a; wstrb = s; wdata = d;
        tick();
        chk("wr_lo_cs", {31'b0, cs}, 32'd1);
        chk("wr_lo_wren", {31'b0, wren}, 32'd1);
        chk("wr_lo_addr", {18'b0, sp_addr}, {18'b0, lo_a});
        chk("wr_lo_datain", {16'b0, datain}, {16'b0, lo_d});
        chk("wr_lo_mask", {28'b0, mask}, {28'b0, lo_m});
        chk("wr_lo_ready", {31'b0, ready}, 32'd0);
        tick();
        chk("wr_hi_cs", {31'b0, cs}, 32'd1);
        chk("wr_hi_addr", {18'b0, sp_addr}, {18'b0, lo_a | 14'h1});
        chk("wr_hi_datain", {16'b0, datain}, {16'b0, hi_d});
        chk("wr_hi_mask", {28'b0, mask}, {28'b0, hi_m});
        tick();
        chk("wr_done_ready", {31'b0, ready}, 32'd1);
        chk("wr_done_cs", {31'b0, cs}, 32'd0);
    endtask

    task automatic read_txn(input logic [12:0] a, input logic [13:0] lo_a, input logic [31:0] exp);
        valid = 1'b1; addr = a; wstrb = 4'b0000; wdata = 32'h0;
        tick();
        chk("rd_lo_cs", {31'b0, cs}, 32'd1);
        chk("rd_lo_wren", {31'b0, wren}, 32'd0);
        chk("rd_lo_addr", {18'b0, sp_addr}, {18'b0, lo_a});
        chk("rd_lo_mask", {28'b0, mask}, 32'd0);
        tick();
        chk("rd_hi_cs", {31'b0, cs}, 32'd1);
        chk("rd_hi_wren", {31'b0, wren}, 32'd0);
        chk("rd_hi_addr", {18'b0, sp_addr}, {18'b0, lo_a | 14'h1});
        tick();
        chk("rd_cap_cs", {31'b0, cs}, 32'd0);
        chk("rd_cap_ready", {31'b0, ready}, 32'd0);
        tick();
        chk("rd_done_ready", {31'b0, ready}, 32'd1);
        chk("rd_done_rdata", rdata, exp);
    endtask

    initial begin
        reset_n = 1'b0; valid = 1'b0; addr = '0; wstrb = '0; wdata = '0;
        tick();
        tick();
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", {18'b0, sp_addr}, 32'd0);
        chk("rst_datain", {16'b0, datain}, 32'd0);
        chk("rst_mask", {28'b0, mask}, 32'd0);
        chk("rst_wren", {31'b0, wren}, 32'd0);
        chk("rst_cs", {31'b0, cs}, 32'd0);
        chk("rst_sleep", {31'b0, sleep}, 32'd0);
        chk("rst_standby", {31'b0, standby}, 32'd0);
        chk("rst_poweroff", {31'b0, poweroff}, 32'd1);
        reset_n = 1'b1;
        write_txn(13'h0005, 4'b1111, 32'hDEADBEEF, 14'h000A, 16'hBEEF, 4'hF, 16'hDEAD, 4'hF);
        tick();
        read_txn(13'h0005, 14'h000A, 32'hDEADBEEF);
        tick();
        chk("rdata_hold", rdata, 32'hDEADBEEF);
        write_txn(13'h0005, 4'b0100, 32'h11223344, 14'h000A, 16'h3344, 4'h0, 16'h1122, 4'h3);
        tick();
        read_txn(13'h0005, 14'h000A, 32'hDE22BEEF);
        tick();
        write_txn(13'h1FFF, 4'b1111, 32'h12345678, 14'h3FFE, 16'h5678, 4'hF, 16'h1234, 4'hF);
        tick();
        read_txn(13'h1FFF, 14'h3FFE, 32'h12345678);
        addr = 13'h0003; wstrb = 4'b1111; wdata = 32'hA5A55A5A;
        tick();
        chk("done_ignored_cs", {31'b0, cs}, 32'd0);
        chk("done_ignored_ready", {31'b0, ready}, 32'd0);
        tick();
        chk("post_done_cs", {31'b0, cs}, 32'd1);
        chk("post_done_addr", {18'b0, sp_addr}, 32'h0006);
        chk("post_done_datain", {16'b0, datain}, 32'h5A5A);
        tick();
        chk("post_done_hi_addr", {18'b0, sp_addr}, 32'h0007);
        tick();
        chk("post_done_ready", {31'b0, ready}, 32'd1);
        tick();
        valid = 1'b1; addr = 13'h0010; wstrb = 4'b1111; wdata = 32'hCAFEF00D;
        tick();
        chk("mid_rst_pre_cs", {31'b0, cs}, 32'd1);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_cs", {31'b0, cs}, 32'd0);
        chk("mid_rst_wren", {31'b0, wren}, 32'd0);
        chk("mid_rst_mask", {28'b0, mask}, 32'd0);
        chk("mid_rst_ready", {31'b0, ready}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_cs", {31'b0, cs}, 32'd1);
        chk("post_rst_addr", {18'b0, sp_addr}, 32'h0020);
        chk("post_rst_ready", {31'b0, ready}, 32'd0);
        tick();
        chk("post_rst_hi_ready", {31'b0, ready}, 32'd0);
        tick();
        chk("post_rst_done", {31'b0, ready}, 32'd1);
        tick();
        read_txn(13'h0003, 14'h0006, 32'hA5A55A5A);
        tick();
        read_txn(13'h0010, 14'h0020, 32'hCAFEF00D);
        tick();
        valid = 1'b0; reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("sleep_cycle7", {31'b0, sleep}, 32'd0);
        tick();
        chk("sleep_cycle8", {31'b0, sleep}, 32'd1);
        chk("sleep_cs", {31'b0, cs}, 32'd0);
        valid = 1'b1; addr = 13'h0005; wstrb = 4'b0000; wdata = 32'h0;
        tick();
        chk("wake_sleep", {31'b0, sleep}, 32'd0);
        chk("wake_cs1", {31'b0, cs}, 32'd0);
        tick();
        tick();
        chk("wake_cs3", {31'b0, cs}, 32'd0);
        tick();
        chk("wake_lo_cs", {31'b0, cs}, 32'd1);
        chk("wake_lo_addr", {18'b0, sp_addr}, 32'h000A);
        tick();
        chk("wake_hi_cs", {31'b0, cs}, 32'd1);
        chk("wake_hi_addr", {18'b0, sp_addr}, 32'h000B);
        tick();
        chk("wake_cap_ready", {31'b0, ready}, 32'd0);
        tick();
        chk("wake_done_ready", {31'b0, ready}, 32'd1);
        chk("wake_done_rdata", rdata, 32'hDE22BEEF);
        tick();
        valid = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spram_bus_controller.md
# spram_bus_controller

Bus-side initiator for one 16-bit iCE40 SPRAM (16K × 16). It accepts 32-bit word requests on a valid/ready bus and splits each request into two back-to-back halfword SPRAM accesses. For writes, it translates byte strobes into SPRAM nibble write masks. It also sleeps the SPRAM after a configurable idle period and wakes it on demand. It sits between the CPU/DMA arbiter and the SPRAM primitive.

## Interface
- IDLE_SLEEP_CYCLES, 64: consecutive idle cycles before SPRAM sleep; 0 disables sleep
- WAKE_CYCLES, 3: wait cycles after releasing sleep before the first access; minimum 1
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- bus_valid  in  1  request pending; held until bus_ready, dropped in the cycle after bus_ready
- bus_address  in  13  32-bit word address
- bus_wstrb  in  4  byte write strobes; 0000 = read
- bus_wdata  in  32  write data
- bus_ready  out  1  one-cycle completion pulse
- bus_rdata  out  32  read data, valid while bus_ready=1 and held until the next read completes
- spram_address  out  14  halfword address
- spram_datain  out  16  write halfword
- spram_maskwren  out  4  nibble write enables
- spram_wren  out  1  write enable
- spram_chipselect  out  1  access strobe
- spram_standby  out  1  constant 0
- spram_sleep  out  1  sleep request
- spram_poweroff  out  1  constant 1 (powered)
- spram_dataout  in  16  SPRAM registered read data, valid the cycle after the SPRAM samples a read

## Operation
- States: IDLE, LO, HI, CAP (read only), DONE, SLEEP, WAKE.
- IDLE + bus_valid → latch address, wstrb and wdata → LO.
- LO: drive address {A,0}.
  - Write: datain = wdata[15:0].
  - Read: datain = 0.
- HI: drive address {A,1}.
  - Write: datain = wdata[31:16].
  - Read: capture spram_dataout (the low half) into rdata[15:0].
- CAP (read only): capture spram_dataout into rdata[31:16].
- DONE: bus_ready=1, then → IDLE.
- Mask mapping:
  - LO mask = {wstrb[1],wstrb[1],wstrb[0],wstrb[0]}.
  - HI mask = {wstrb[3],wstrb[3],wstrb[2],wstrb[2]}.
  - A partial write still issues both halfword cycles, with the mask possibly 0000. Timing is fixed.
- chipselect=1 only in LO and HI. wren = (wstrb≠0) in LO/HI, else 0. mask=0 and datain=0 outside write cycles.
- All spram_* outputs and bus_* outputs are registered. They reflect the current state.
- Idle counter:
  - Increments each IDLE cycle with bus_valid=0.
  - Clears on accept and in every other state.
  - When it reaches IDLE_SLEEP_CYCLES (nonzero) → SLEEP, with spram_sleep=1.
  - If bus_valid=1 in the same cycle the counter would expire, accept wins.
- SLEEP + bus_valid → latch request, spram_sleep←0, then WAKE for exactly WAKE_CYCLES cycles → LO.
- bus_valid in the DONE cycle is ignored.
- Address arithmetic: {A,0}/{A,1}. No carry, so A=0x1FFF maps to 0x3FFE/0x3FFF.
- Reset values:
  - State IDLE, counter 0.
  - bus_ready=0, bus_rdata=0.
  - spram_address=0, datain=0, maskwren=0, wren=0, chipselect=0.
  - sleep=0, standby=0, poweroff=1.
- Reset mid-operation: the next cycle shows reset values and no bus_ready pulse. A partially written word (low half only) stays in the SPRAM; this is accepted.

## Timing
- T = cycle bus_valid is sampled in IDLE.
- Write:
  - T+1: LO access.
  - T+2: HI access.
  - T+3: bus_ready.
  - Next accept no earlier than T+4.
- Read:
  - T+1: LO access.
  - T+2: HI access; low half captured at the end of T+2.
  - T+3: high half captured at the end of T+3.
  - T+4: bus_ready with bus_rdata.
  - Next accept no earlier than T+5.
- From SLEEP (valid sampled at T):
  - spram_sleep=0 from T+1.
  - WAKE spans T+1..T+WAKE_CYCLES.
  - LO at T+WAKE_CYCLES+1.
  - bus_ready at T+WAKE_CYCLES+3 (write) or T+WAKE_CYCLES+4 (read).
- Sleep entry: after reset with bus_valid=0, spram_sleep rises in cycle IDLE_SLEEP_CYCLES, counting the first post-reset cycle as 0.

## Test plan
- Write A=0x005, wstrb=1111, data 0xDEADBEEF:
  - T+1: addr 0x000A, datain 0xBEEF, mask 1111, wren=1, cs=1.
  - T+2: addr 0x000B, datain 0xDEAD.
  - T+3: bus_ready=1.
- Read A=0x005 → cs=1 and wren=0 at T+1 and T+2. T+4: bus_ready=1, bus_rdata=0xDEADBEEF.
- Write A=0x005, wstrb=0100, data 0x11223344 → T+1: mask 0000. T+2: mask 0011, datain 0x1122. Readback gives 0xDE22BEEF.
- IDLE_SLEEP_CYCLES=8, WAKE_CYCLES=3, bus_valid low from reset:
  - spram_sleep=1 at cycle 8.
  - Read at T in SLEEP → sleep=0 at T+1, cs=1 at T+4/T+5, bus_ready at T+7.
- reset_n=0 sampled during T+1 of a write → next cycle cs=0, wren=0, maskwren=0; bus_ready never pulses. Request accepted 1 cycle after reset release.
- Read A=0x1FFF → spram_address 0x3FFE then 0x3FFF. bus_valid asserted in the DONE cycle is not accepted until IDLE.
